// File: rtl/cpu_pc_sequencer.sv
// Fetch-PC sequencer: advances the PC on accepted fetches and applies branch/JAL/JALR redirects.
// Define CPU_MISALIGN_TRAP_EN to trap on misaligned targets instead of silently aligning them.
module cpu_pc_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    output logic        fetch_valid,
    input  logic        fetch_ready,
    output logic [31:0] fetch_pc,
    input  logic        resolve_valid,
    input  logic [1:0]  resolve_type,
    input  logic [31:0] resolve_pc,
    input  logic [31:0] resolve_imm,
    input  logic [31:0] resolve_base,
    input  logic        condition_satisfied,
    output logic        redirect,
    output logic        link_valid,
    output logic [31:0] link_pc,
    output logic        trap,
    output logic [31:0] trap_addr,
    input  logic        trap_ack
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, TRAP} state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic        redirect_q;
    logic        linkValid_q;
    logic [31:0] linkPc_q;

    logic        acceptWindow;
    logic        isJump;
    logic        isTaken;
    logic [31:0] rawTarget;
    logic [31:0] target;

    // Resolutions only matter while the front end is live (RUN or FLUSH).
    assign acceptWindow = (state_q == RUN) || (state_q == FLUSH);
    assign isJump       = resolve_valid && acceptWindow &&
                          ((resolve_type == 2'b01) || (resolve_type == 2'b10));
    assign isTaken      = isJump || (resolve_valid && acceptWindow &&
                          (resolve_type == 2'b00) && condition_satisfied);
    assign rawTarget    = (resolve_type == 2'b10) ? ((resolve_base + resolve_imm) & ~32'h1)
                                                  : (resolve_pc + resolve_imm);

`ifdef CPU_MISALIGN_TRAP_EN
    logic        trap_q;
    logic [31:0] trapAddr_q;
    logic        misaligned;

    assign target     = rawTarget;
    assign misaligned = (rawTarget[1:0] != 2'b00);
    assign trap       = trap_q;
    assign trap_addr  = trapAddr_q;
`else
    logic unusedTrapInputs;

    assign target           = rawTarget & ~32'h3;
    assign trap             = 1'b0;
    assign trap_addr        = 32'h0;
    assign unusedTrapInputs = trap_ack ^ (|TRAP_VECTOR);
`endif

    assign fetch_valid = (state_q == RUN) && !stall;
    assign fetch_pc    = pc_q;
    assign redirect    = redirect_q;
    assign link_valid  = linkValid_q;
    assign link_pc     = linkPc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            redirect_q  <= 1'b0;
            linkValid_q <= 1'b0;
            linkPc_q    <= 32'h0;
`ifdef CPU_MISALIGN_TRAP_EN
            trap_q      <= 1'b0;
            trapAddr_q  <= 32'h0;
`endif
        end else begin
            redirect_q  <= 1'b0;
            linkValid_q <= 1'b0;
            // The link write happens even when the jump itself traps.
            if (isJump) begin
                linkValid_q <= 1'b1;
                linkPc_q    <= resolve_pc + 32'd4;
            end
            case (state_q)
                IDLE: state_q <= RUN;
                RUN, FLUSH: begin
                    if (isTaken) begin
`ifdef CPU_MISALIGN_TRAP_EN
                        if (misaligned) begin
                            trapAddr_q <= target;
                            trap_q     <= 1'b1;
                            state_q    <= TRAP;
                        end else
`endif
                        begin
                            pc_q       <= target;
                            redirect_q <= 1'b1;
                            state_q    <= FLUSH;
                        end
                    end else begin
                        if (fetch_valid && fetch_ready) begin
                            pc_q <= pc_q + 32'd4;
                        end
                        state_q <= RUN;
                    end
                end
                TRAP: begin
`ifdef CPU_MISALIGN_TRAP_EN
                    if (trap_ack) begin
                        pc_q    <= TRAP_VECTOR;
                        trap_q  <= 1'b0;
                        state_q <= FLUSH;
                    end
`else
                    state_q <= RUN;
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_pc_sequencer.sv
// Scoreboard bench for cpu_pc_sequencer: directed vectors push expected fetches, redirects,
// links and traps into queues; a negedge monitor pops and compares whenever the DUT presents one.
module tb_cpu_pc_sequencer;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_pc;
    logic        resolve_valid;
    logic [1:0]  resolve_type;
    logic [31:0] resolve_pc;
    logic [31:0] resolve_imm;
    logic [31:0] resolve_base;
    logic        condition_satisfied;
    logic        redirect;
    logic        link_valid;
    logic [31:0] link_pc;
    logic        trap;
    logic [31:0] trap_addr;
    logic        trap_ack;

    int errors = 0;
    int checks = 0;

    logic [31:0] fetchQ[$];
    logic [31:0] redirectQ[$];
    logic [31:0] linkQ[$];
    logic [31:0] trapQ[$];
    logic        trapPrev = 1'b0;

    localparam logic [1:0] T_BR   = 2'b00;
    localparam logic [1:0] T_JAL  = 2'b01;
    localparam logic [1:0] T_JALR = 2'b10;
    localparam logic [1:0] T_NONE = 2'b11;

    cpu_pc_sequencer dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .stall               (stall),
        .fetch_valid         (fetch_valid),
        .fetch_ready         (fetch_ready),
        .fetch_pc            (fetch_pc),
        .resolve_valid       (resolve_valid),
        .resolve_type        (resolve_type),
        .resolve_pc          (resolve_pc),
        .resolve_imm         (resolve_imm),
        .resolve_base        (resolve_base),
        .condition_satisfied (condition_satisfied),
        .redirect            (redirect),
        .link_valid          (link_valid),
        .link_pc             (link_pc),
        .trap                (trap),
        .trap_addr           (trap_addr),
        .trap_ack            (trap_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic noteUnexpected(input string name, input logic [31:0] actual);
        checks++;
        errors++;
        $display("[TB] FAIL %s: unexpected event with value 0x%08h, expected none", name, actual);
    endtask

    // Drive one cycle of inputs and advance to just after the next rising edge.
    task automatic applyStimulus(input logic stallV, input logic readyV, input logic valid,
                                 input logic [1:0] typ, input logic [31:0] pc, input logic [31:0] imm,
                                 input logic [31:0] base, input logic cond, input logic ack);
        stall               = stallV;
        fetch_ready         = readyV;
        resolve_valid       = valid;
        resolve_type        = typ;
        resolve_pc          = pc;
        resolve_imm         = imm;
        resolve_base        = base;
        condition_satisfied = cond;
        trap_ack            = ack;
        @(posedge clk);
        #1;
    endtask

    task automatic tick(input logic stallV, input logic readyV);
        applyStimulus(stallV, readyV, 1'b0, T_NONE, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    // Monitor: consume the scoreboard whenever the DUT presents an event.
    always @(negedge clk) begin
        if (rst_n) begin
            if (fetch_valid && fetch_ready) begin
                if (fetchQ.size() == 0) noteUnexpected("fetch", fetch_pc);
                else checkOutput("fetch_pc", fetch_pc, fetchQ.pop_front());
            end
            if (redirect) begin
                if (redirectQ.size() == 0) noteUnexpected("redirect", fetch_pc);
                else begin
                    checkOutput("redirect_target", fetch_pc, redirectQ.pop_front());
                    checkOutput("redirect_fetch_valid", 32'(fetch_valid), 32'h0);
                end
            end
            if (link_valid) begin
                if (linkQ.size() == 0) noteUnexpected("link", link_pc);
                else checkOutput("link_pc", link_pc, linkQ.pop_front());
            end
            if (trap && !trapPrev) begin
                if (trapQ.size() == 0) noteUnexpected("trap", trap_addr);
                else begin
                    checkOutput("trap_addr", trap_addr, trapQ.pop_front());
                    checkOutput("trap_no_fetch", 32'(fetch_valid), 32'h0);
                end
            end
            trapPrev = trap;
        end else begin
            trapPrev = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        stall = 1'b0;
        fetch_ready = 1'b0;
        resolve_valid = 1'b0;
        resolve_type = T_NONE;
        resolve_pc = 32'h0;
        resolve_imm = 32'h0;
        resolve_base = 32'h0;
        condition_satisfied = 1'b0;
        trap_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("rst_fetch_pc", fetch_pc, 32'h0);
        checkOutput("rst_fetch_valid", 32'(fetch_valid), 32'h0);
        checkOutput("rst_redirect", 32'(redirect), 32'h0);
        checkOutput("rst_link_valid", 32'(link_valid), 32'h0);
        checkOutput("rst_link_pc", link_pc, 32'h0);
        checkOutput("rst_trap", 32'(trap), 32'h0);
        checkOutput("rst_trap_addr", trap_addr, 32'h0);
        @(posedge clk);
        #1;

        // Reset release: one IDLE cycle, then sequential fetch.
        fetchQ.push_back(32'h0);
        fetchQ.push_back(32'h4);
        fetchQ.push_back(32'h8);
        fetchQ.push_back(32'hC);
        rst_n = 1'b1;
        fetch_ready = 1'b1;
        @(negedge clk);
        checkOutput("idle_fetch_valid", 32'(fetch_valid), 32'h0);
        @(posedge clk);
        #1;
        repeat (4) tick(1'b0, 1'b1);

        // Taken branch 0x40 - 16 -> 0x30.
        redirectQ.push_back(32'h30);
        applyStimulus(1'b0, 1'b0, 1'b1, T_BR, 32'h40, 32'hFFFF_FFF0, 32'h0, 1'b1, 1'b0);
        fetchQ.push_back(32'h30);
        fetchQ.push_back(32'h34);
        repeat (3) tick(1'b0, 1'b1);

        // Not-taken branch and an ignored type-11 resolution: PC keeps incrementing.
        fetchQ.push_back(32'h38);
        fetchQ.push_back(32'h3C);
        applyStimulus(1'b0, 1'b1, 1'b1, T_BR, 32'h40, 32'hFFFF_FFF0, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, T_NONE, 32'h40, 32'hFFFF_FFF0, 32'h0, 1'b1, 1'b0);

        // JALR clears bit 0 of the target; link appears with the redirect.
        redirectQ.push_back(32'h1004);
        linkQ.push_back(32'h204);
        applyStimulus(1'b0, 1'b0, 1'b1, T_JALR, 32'h200, 32'h4, 32'h1001, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("jalr_link_with_redirect", 32'({redirect, link_valid}), 32'h3);
        tick(1'b0, 1'b0);

        // JAL under a 3-cycle stall still redirects; PC holds until the stall drops.
        redirectQ.push_back(32'h180);
        linkQ.push_back(32'h84);
        fetchQ.push_back(32'h180);
        applyStimulus(1'b1, 1'b1, 1'b1, T_JAL, 32'h80, 32'h100, 32'h0, 1'b0, 1'b0);
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        tick(1'b0, 1'b1);

        // Wrap: 0xFFFF_FFFC + 4 -> 0.
        redirectQ.push_back(32'hFFFF_FFFC);
        linkQ.push_back(32'h4);
        fetchQ.push_back(32'hFFFF_FFFC);
        fetchQ.push_back(32'h0);
        applyStimulus(1'b0, 1'b0, 1'b1, T_JAL, 32'h0, 32'hFFFF_FFFC, 32'h0, 1'b0, 1'b0);
        repeat (3) tick(1'b0, 1'b1);

        // Reset in the middle of FLUSH.
        redirectQ.push_back(32'h310);
        linkQ.push_back(32'h304);
        applyStimulus(1'b0, 1'b0, 1'b1, T_JAL, 32'h300, 32'h10, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("flush_rst_fetch_pc", fetch_pc, 32'h0);
        checkOutput("flush_rst_redirect", 32'(redirect), 32'h0);
        checkOutput("flush_rst_link_valid", 32'(link_valid), 32'h0);
        checkOutput("flush_rst_fetch_valid", 32'(fetch_valid), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        // A resolution during IDLE is ignored.
        applyStimulus(1'b0, 1'b0, 1'b1, T_JAL, 32'h500, 32'h8, 32'h0, 1'b0, 1'b0);

        // Misaligned JAL target 0x16.
        linkQ.push_back(32'h14);
`ifdef CPU_MISALIGN_TRAP_EN
        trapQ.push_back(32'h16);
        applyStimulus(1'b0, 1'b0, 1'b1, T_JAL, 32'h10, 32'h6, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, T_JAL, 32'h700, 32'h8, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("trap_held", 32'(trap), 32'h1);
        applyStimulus(1'b0, 1'b0, 1'b0, T_NONE, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("trap_vector_pc", fetch_pc, 32'h100);
        checkOutput("trap_vector_fetch_valid", 32'(fetch_valid), 32'h0);
        checkOutput("trap_cleared", 32'(trap), 32'h0);
        fetchQ.push_back(32'h100);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
`else
        redirectQ.push_back(32'h14);
        fetchQ.push_back(32'h14);
        applyStimulus(1'b0, 1'b0, 1'b1, T_JAL, 32'h10, 32'h6, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, T_NONE, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        tick(1'b0, 1'b1);
`endif
        tick(1'b0, 1'b0);

        // Back-to-back taken jumps: the second arrives during FLUSH and restarts it.
        redirectQ.push_back(32'h420);
        redirectQ.push_back(32'h640);
        linkQ.push_back(32'h404);
        linkQ.push_back(32'h604);
        fetchQ.push_back(32'h640);
        applyStimulus(1'b0, 1'b0, 1'b1, T_JAL, 32'h400, 32'h20, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, T_JAL, 32'h600, 32'h40, 32'h0, 1'b0, 1'b0);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        repeat (3) tick(1'b0, 1'b0);

        checkOutput("fetchQ_drained", 32'(fetchQ.size()), 32'h0);
        checkOutput("redirectQ_drained", 32'(redirectQ.size()), 32'h0);
        checkOutput("linkQ_drained", 32'(linkQ.size()), 32'h0);
        checkOutput("trapQ_drained", 32'(trapQ.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu_pc_sequencer.md
# cpu_pc_sequencer

Program-counter sequencer for the CPU front end. Holds the fetch PC, advances it on each accepted fetch, and applies control-flow redirects for branches, JAL and JALR. It sits directly downstream of the execute-stage branch tester: it consumes the tester's `condition_satisfied` flag together with the resolved instruction's PC, immediate and base register. It emits the redirect/flush pulse and the link value for the register file.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset.
- `TRAP_VECTOR`, 32'h0000_0100, PC loaded after a misaligned-target trap is acknowledged.

Reset is asynchronous and active-low; one clock.

- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `stall`  in  1  front-end hold: freezes PC and forces `fetch_valid` low.
- `fetch_valid`  out  1  `fetch_pc` is a valid fetch request.
- `fetch_ready`  in  1  fetch stage accepts the request.
- `fetch_pc`  out  32  current PC.
- `resolve_valid`  in  1  execute stage presents a control-flow instruction.
- `resolve_type`  in  2  00 branch, 01 JAL, 10 JALR, 11 ignored.
- `resolve_pc`  in  32  PC of the resolving instruction.
- `resolve_imm`  in  32  sign-extended offset.
- `resolve_base`  in  32  rs1 value (JALR only).
- `condition_satisfied`  in  1  branch outcome from the branch tester.
- `redirect`  out  1  one-cycle flush pulse for younger instructions.
- `link_valid`  out  1  one-cycle pulse: `link_pc` is valid for writeback.
- `link_pc`  out  32  `resolve_pc + 4`.
- `trap`  out  1  misaligned-target trap pending.
- `trap_addr`  out  32  offending target.
- `trap_ack`  in  1  trap handler acknowledges the trap.

## Operation
- States: IDLE, RUN, FLUSH, TRAP.
- Reset values: state IDLE, `fetch_pc`=`RESET_PC`, `fetch_valid`=0, `redirect`=0, `link_valid`=0, `link_pc`=0, `trap`=0, `trap_addr`=0.
- IDLE: `fetch_valid`=0; always goes to RUN on the next cycle.
- RUN: `fetch_valid` = !`stall`.
  - When `fetch_valid && fetch_ready`, PC <= PC + 4. Arithmetic is modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- Resolution is accepted in RUN and FLUSH only; it is ignored in IDLE and TRAP.
  - taken = JAL | JALR | (branch & `condition_satisfied`).
  - Branch/JAL target = `resolve_pc + resolve_imm`.
  - JALR target = (`resolve_base + resolve_imm`) & ~32'h1.
  - Taken: PC <= target and state -> FLUSH. This has priority over fetch advance and over `stall`.
  - Not taken: no PC effect.
  - JAL/JALR: `link_pc` <= `resolve_pc + 4`, and `link_valid` pulses, whether or not the jump traps.
- FLUSH: `fetch_valid`=0 for exactly one cycle, then RUN. A taken resolution arriving during FLUSH restarts FLUSH with the new target.
- TRAP (macro enabled only): `fetch_valid`=0 and `trap` is held high.
  - `trap_ack` causes PC <= `TRAP_VECTOR`, `trap` <= 0, state -> FLUSH.
- Type 11: no state change, no pulses.

## Timing
- Cycle N: `resolve_valid` with a taken target T.
- Cycle N+1: `redirect`=1, `fetch_pc`=T, `fetch_valid`=0.
- Cycle N+2: `fetch_valid`=1 with T. Redirect-to-fetch latency is 2 cycles.
- `link_valid`/`link_pc` are registered and appear in cycle N+1.
- `redirect` and `link_valid` are single-cycle pulses. Back-to-back taken resolutions produce back-to-back pulses.
- After `rst_n` rises, the first `fetch_valid` is on the second rising edge (one IDLE cycle).
- Reset mid-operation (including mid-FLUSH or TRAP) immediately returns all outputs to their reset values; pending pulses are lost.
- `trap` rises the cycle after the offending resolution. The cycle after `trap_ack`, `fetch_pc`=`TRAP_VECTOR` with `fetch_valid`=0; fetch resumes the cycle after that.

## Configuration
- `CPU_MISALIGN_TRAP_EN` defined:
  - A taken target with bits [1:0] != 0 (after JALR bit-0 clear) does not redirect and does not pulse `redirect`.
  - Instead `trap_addr` <= target, `trap`=1, and state -> TRAP.
- Undefined:
  - Target bits [1:0] are forced to 00 and the redirect proceeds normally.
  - TRAP is unreachable, `trap`/`trap_addr` are tied 0, and `trap_ack` is ignored.

## Test plan
- Reset release with `fetch_ready`=1, `RESET_PC`=0 -> `fetch_pc` sequence 0, 4, 8, 12. `fetch_valid` first high on the second edge after reset.
- Branch at `resolve_pc`=0x40, imm=-16, `condition_satisfied`=1 -> next cycle `redirect`=1, `fetch_pc`=0x30; fetch of 0x30 one cycle later. Same stimulus with `condition_satisfied`=0 -> no redirect, PC keeps incrementing.
- JALR base=0x1001, imm=4, pc=0x200 -> target 0x1004. `link_pc`=0x204 with `link_valid`=1 in the same cycle as `redirect`.
- `stall`=1 for 3 cycles while a JAL at 0x80 with imm=0x100 resolves -> redirect is still taken, `fetch_pc`=0x180, and PC holds until `stall` drops.
- PC=0xFFFF_FFFC accepted -> `fetch_pc`=0. Reset asserted during FLUSH -> `fetch_pc`=`RESET_PC`, `redirect`=0 immediately.
- Macro on: JAL pc=0x10, imm=6 -> `trap`=1, `trap_addr`=0x16, no `redirect`, `link_pc`=0x14. `trap_ack` -> `fetch_pc`=0x100. Macro off: same stimulus -> `redirect`, `fetch_pc`=0x14.
